bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_arbit_pkg.sv | 28 ++
 rtl/bus_rr_pick.sv | 30 +++
 rtl/bus_rr_arbiter.sv | 115 +++++++++++
 tb/tb_bus_rr_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bus_arbit_pkg.sv
// Shared definitions for the round-robin bus arbiter.
// Holds master count, id/counter widths, default hold limit, the
// per-cycle arbitration decision enum and the owner+PARK state encoding.
package bus_arbit_pkg;

  localparam int NUM_MASTERS      = 4;
  localparam int ID_W             = 2;
  localparam int CNT_W            = 8;
  localparam int MAX_HOLD_DEFAULT = 8;

  // Registered state is {park flag, owner id}; these are the flag values.
  localparam logic            PARK_FLAG_OWN  = 1'b0;
  localparam logic            PARK_FLAG_PARK = 1'b1;
  localparam logic [ID_W-1:0] RESET_OWNER    = 2'd0;

  // Decision taken each cycle from the current state and sampled requests.
  typedef enum logic [1:0] {
    ST_OWN           = 2'd0,
    ST_HANDOVER_EVAL = 2'd1,
    ST_PARK          = 2'd2
  } arb_state_e;

  // Binary master id to one-hot grant vector.
  function automatic logic [NUM_MASTERS-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Rotating-priority search for the next bus owner.
// Ports:
//   req     - request vector, bit i = master i
//   cur_id  - current owner; searched last-excluded, order cur_id+1..cur_id+3
//   next_id - first requester found in that order (cur_id when none)
//   found   - 1 when some master other than cur_id is requesting
module bus_rr_pick
  import bus_arbit_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        cur_id,
  output logic [ID_W-1:0]        next_id,
  output logic                   found
);

  logic [ID_W-1:0] idx_s;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    next_id = cur_id;
    found   = 1'b0;
    idx_s   = cur_id;
    for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
      idx_s   = cur_id + ID_W'(k);
      next_id = req[idx_s] ? idx_s : next_id;
      found   = found | req[idx_s];
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin bus arbiter with a per-owner hold limit.
// The bus is always granted to exactly one master; it parks on the last
// owner when nobody else wants it.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset (parks on M0)
//   M_req    - level-sensitive requests, bit i = master i
//   M_grant  - registered one-hot grant
//   grant_id - registered binary id of the granted master
//   hold_cnt - registered count of cycles the owner has held with request high
//   preempt  - one-cycle pulse on the first cycle of a limit-forced handover
module bus_rr_arbiter
  import bus_arbit_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] M_req,
  output logic [NUM_MASTERS-1:0] M_grant,
  output logic [ID_W-1:0]        grant_id,
  output logic [CNT_W-1:0]       hold_cnt,
  output logic                   preempt
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

  logic [ID_W-1:0]        owner_r;
  logic                   park_r;
  logic [NUM_MASTERS-1:0] grant_r;
  logic [CNT_W-1:0]       hold_cnt_r;
  logic                   preempt_r;

  logic [ID_W-1:0]        pick_id_s;
  logic                   pick_found_s;
  logic                   own_req_s;
  logic                   at_limit_s;
  arb_state_e             eval_s;
  logic [ID_W-1:0]        next_owner_s;
  logic                   next_park_s;
  logic [CNT_W-1:0]       next_cnt_s;
  logic                   next_preempt_s;

  bus_rr_pick u_pick (
    .req     (M_req),
    .cur_id  (owner_r),
    .next_id (pick_id_s),
    .found   (pick_found_s)
  );

  // Next-state decision: keep, hand over (voluntary or forced), or park.
  always_comb begin
    next_owner_s   = owner_r;
    next_park_s    = park_r;
    next_cnt_s     = hold_cnt_r;
    next_preempt_s = 1'b0;
    own_req_s      = M_req[owner_r];
    // A parked owner always has a zero count, so it can never be at the limit.
    at_limit_s     = (park_r == PARK_FLAG_OWN) && (hold_cnt_r == HOLD_LIMIT);

    if (pick_found_s && (!own_req_s || at_limit_s)) begin
      eval_s = ST_HANDOVER_EVAL;
    end else if (!own_req_s) begin
      eval_s = ST_PARK;
    end else begin
      eval_s = ST_OWN;
    end

    case (eval_s)
      ST_OWN: begin
        next_park_s = PARK_FLAG_OWN;
        next_cnt_s  = (hold_cnt_r == HOLD_LIMIT) ? HOLD_LIMIT : hold_cnt_r + 8'd1;
      end
      ST_HANDOVER_EVAL: begin
        next_owner_s   = pick_id_s;
        next_park_s    = PARK_FLAG_OWN;
        next_cnt_s     = 8'd0;
        // Owner still requesting means the limit forced it off the bus.
        next_preempt_s = own_req_s;
      end
      ST_PARK: begin
        next_park_s = PARK_FLAG_PARK;
        next_cnt_s  = 8'd0;
      end
      default: begin
        next_owner_s = RESET_OWNER;
        next_park_s  = PARK_FLAG_PARK;
        next_cnt_s   = 8'd0;
      end
    endcase
  end

  // State and output registers; reset parks the bus on M0 immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_r    <= RESET_OWNER;
      park_r     <= PARK_FLAG_PARK;
      grant_r    <= 4'b0001;
      hold_cnt_r <= 8'd0;
      preempt_r  <= 1'b0;
    end else begin
      owner_r    <= next_owner_s;
      park_r     <= next_park_s;
      grant_r    <= id_to_onehot(next_owner_s);
      hold_cnt_r <= next_cnt_s;
      preempt_r  <= next_preempt_s;
    end
  end

  assign M_grant  = grant_r;
  assign grant_id = owner_r;
  assign hold_cnt = hold_cnt_r;
  assign preempt  = preempt_r;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios plus random
// request segments, compared every cycle against a behavioural model.
module tb_bus_rr_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int LIM      = MAX_HOLD - 1;

  logic       clk;
  logic       reset_n;
  logic [3:0] M_req;
  logic [3:0] M_grant;
  logic [1:0] grant_id;
  logic [7:0] hold_cnt;
  logic       preempt;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  int m_owner = 0;
  int m_hold  = 0;
  int m_pre   = 0;

  // starvation tracking based on observed grants
  int wait_cnt [4];
  int max_wait = 0;

  bus_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .M_req    (M_req),
    .M_grant  (M_grant),
    .grant_id (grant_id),
    .hold_cnt (hold_cnt),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_grant"}, 32'(M_grant), 32'd1);
    check_eq({tag, "_id"}, 32'(grant_id), 32'd0);
    check_eq({tag, "_hold"}, 32'(hold_cnt), 32'd0);
    check_eq({tag, "_preempt"}, 32'(preempt), 32'd0);
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_hold  = 0;
    m_pre   = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
  endtask

  // Advance the model by one rising edge with request vector r.
  task automatic model_edge(input logic [3:0] r);
    int cand;
    cand = -1;
    for (int k = 1; k < 4; k++) begin
      if (cand < 0 && r[(m_owner + k) % 4]) cand = (m_owner + k) % 4;
    end
    if (cand >= 0 && (!r[m_owner] || m_hold == LIM)) begin
      m_pre   = r[m_owner] ? 1 : 0;
      m_owner = cand;
      m_hold  = 0;
    end else begin
      m_pre  = 0;
      m_hold = r[m_owner] ? ((m_hold + 1 > LIM) ? LIM : m_hold + 1) : 0;
    end
  endtask

  task automatic compare_all(input string tag, input logic [3:0] r);
    check_eq({tag, "_grant"}, 32'(M_grant), 32'(1 << m_owner));
    check_eq({tag, "_id"}, 32'(grant_id), 32'(m_owner));
    check_eq({tag, "_hold"}, 32'(hold_cnt), 32'(m_hold));
    check_eq({tag, "_preempt"}, 32'(preempt), 32'(m_pre));
    for (int i = 0; i < 4; i++) begin
      if (r[i] && !M_grant[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  // Drive r for one cycle (optionally glitching mid-cycle), then check.
  task automatic step(input string tag, input logic [3:0] r, input bit glitch);
    M_req = r;
    if (glitch) begin
      #3 M_req = ~r;
      #2 M_req = r;
    end
    @(posedge clk);
    model_edge(r);
    #1;
    compare_all(tag, r);
  endtask

  task automatic run(input string tag, input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) step(tag, r, 1'b0);
  endtask

  initial begin
    logic [3:0] r;
    int len;
    M_req   = 4'b1111;
    reset_n = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    #11;                      // t=12, between edges, reset still held
    check_reset_outputs("rst_hold");
    M_req   = 4'b0000;
    reset_n = 1'b1;

    // release with no requests: stays parked on M0
    run("park0", 4'b0000, 3);
    // voluntary release M0 -> M1
    run("vol_own", 4'b0011, 3);
    run("vol_rel", 4'b0010, 2);
    // limit preemption back and forth between M0 and M1
    run("vol_back", 4'b0001, 1);
    run("limit", 4'b0011, 24);
    // rotation with M1 releasing among 1101
    run("to_m1", 4'b0010, 2);
    run("rot", 4'b1101, 30);
    // sole requester saturation
    run("sole", 4'b0100, 50);
    // mid-ownership reset with M3 owning
    run("m3_own", 4'b1000, 6);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    #2 reset_n = 1'b1;
    run("post_rst", 4'b1000, 3);

    // random request segments, some with intra-cycle glitches
    for (int s = 0; s < 60; s++) begin
      r   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) step("rand", r, ($urandom_range(0, 3) == 0));
    end
    // dense requests to stress the waiting bound
    run("all_req", 4'b1111, 40);

    check_eq("max_wait_ok", 32'(max_wait <= 3 * MAX_HOLD), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
